// File: rtl/booth_divider.sv
// booth_divider: sequential restoring divider, one quotient bit per clock.
// Inverse of the combinational Booth multiplier: quotient*divisor + remainder
// reproduces the dividend (truncating division).
// Optional feature macro: BOOTH_DIV_SIGNED_EN
//   defined   -> signed two's-complement operands and results
//   undefined -> unsigned operands and results
// Latency: start sampled at edge T, results and done valid after edge T+WIDTH+1.
module booth_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef BOOTH_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;          // dividend magnitude, becomes q_mag
  logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;  // raw dividend for divide-by-zero
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   shift_c, trial_c;      // trial subtraction is one bit wider

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

  // Next-state and datapath: capture, restoring iterations, sign fix-up.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    shift_c     = '0;
    trial_c     = '0;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
    a_mag_c = (SIGNED_EN && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    b_mag_c = (SIGNED_EN && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d     = a_mag_c;
          dvs_d     = b_mag_c;
          dvd_raw_d = dividend;
          sign_q_d  = SIGNED_EN && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_r_d  = SIGNED_EN && dividend[WIDTH-1];
          zero_d    = (divisor == '0);
          rem_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        shift_c = {rem_q, dvd_q[WIDTH-1]};
        trial_c = shift_c - {1'b0, dvs_q};
        rem_d   = trial_c[WIDTH] ? shift_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        if (WIDTH > 1) begin
          dvd_d = {dvd_q[WIDTH-2:0], ~trial_c[WIDTH]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dvd_raw_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = sign_q_q ? WIDTH'(-dvd_q) : dvd_q;
          remainder_d = sign_r_q ? WIDTH'(-rem_q) : rem_q;
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dvd_raw_q   <= dvd_raw_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider (WIDTH=4); expected values follow the
// BOOTH_DIV_SIGNED_EN setting of the build.
module tb_booth_divider;

  localparam int W   = 4;
  localparam int LAT = W + 1;  // edges after the start edge until done is seen

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  booth_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one start pulse and count edges until done (bounded).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (quotient !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", quotient); end
    checks++; if (remainder !== 4'b0000) begin failures++; $display("FAIL reset_r got=%b exp=0000", remainder); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic [W-1:0] eq [8];
    logic [W-1:0] er [8];
    logic         ez [8];
    int lat;
`ifdef BOOTH_DIV_SIGNED_EN
    va[0]=4'b0111; vb[0]=4'b0010; eq[0]=4'b0011; er[0]=4'b0001; ez[0]=0; //  7/2
    va[1]=4'b1001; vb[1]=4'b0010; eq[1]=4'b1101; er[1]=4'b1111; ez[1]=0; // -7/2
    va[2]=4'b0110; vb[2]=4'b1100; eq[2]=4'b1111; er[2]=4'b0010; ez[2]=0; //  6/-4
    va[3]=4'b0101; vb[3]=4'b0000; eq[3]=4'b1111; er[3]=4'b0101; ez[3]=1; //  5/0
    va[4]=4'b0100; vb[4]=4'b0010; eq[4]=4'b0010; er[4]=4'b0000; ez[4]=0; //  4/2
    va[5]=4'b1000; vb[5]=4'b1111; eq[5]=4'b1000; er[5]=4'b0000; ez[5]=0; // -8/-1
    va[6]=4'b1000; vb[6]=4'b0011; eq[6]=4'b1110; er[6]=4'b1110; ez[6]=0; // -8/3
    va[7]=4'b1111; vb[7]=4'b0111; eq[7]=4'b0000; er[7]=4'b1111; ez[7]=0; // -1/7
`else
    va[0]=4'd15; vb[0]=4'd4;  eq[0]=4'd3;  er[0]=4'd3; ez[0]=0;
    va[1]=4'd9;  vb[1]=4'd0;  eq[1]=4'd15; er[1]=4'd9; ez[1]=1;
    va[2]=4'd4;  vb[2]=4'd2;  eq[2]=4'd2;  er[2]=4'd0; ez[2]=0;
    va[3]=4'd7;  vb[3]=4'd2;  eq[3]=4'd3;  er[3]=4'd1; ez[3]=0;
    va[4]=4'd13; vb[4]=4'd3;  eq[4]=4'd4;  er[4]=4'd1; ez[4]=0;
    va[5]=4'd15; vb[5]=4'd1;  eq[5]=4'd15; er[5]=4'd0; ez[5]=0;
    va[6]=4'd3;  vb[6]=4'd7;  eq[6]=4'd0;  er[6]=4'd3; ez[6]=0;
    va[7]=4'd8;  vb[7]=4'd15; eq[7]=4'd0;  er[7]=4'd8; ez[7]=0;
`endif
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], lat);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (quotient !== eq[i]) begin failures++; $display("FAIL vec%0d_q got=%b exp=%b", i, quotient, eq[i]); end
      checks++; if (remainder !== er[i]) begin failures++; $display("FAIL vec%0d_r got=%b exp=%b", i, remainder, er[i]); end
      checks++; if (div_by_zero !== ez[i]) begin failures++; $display("FAIL vec%0d_dbz got=%b exp=%b", i, div_by_zero, ez[i]); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL vec%0d_busy got=%b exp=0", i, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL vec%0d_done_width got=%b exp=0", i, done); end
    end
  endtask

  // start held high while busy, operands scrambled: only the first op counts.
  task automatic test_handshake();
    int lat;
    int extra_done;
    @(negedge clk);
    dividend = 4'd7; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hs_busy got=%b exp=1", busy); end
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      dividend = 4'(lat * 5 + 1);
      divisor  = 4'(lat * 3);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (lat !== LAT) begin failures++; $display("FAIL hs_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (quotient !== 4'd3) begin failures++; $display("FAIL hs_q got=%b exp=0011", quotient); end
    checks++; if (remainder !== 4'd1) begin failures++; $display("FAIL hs_r got=%b exp=0001", remainder); end
    extra_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    checks++; if (extra_done !== 0) begin failures++; $display("FAIL hs_extra_activity got=%0d exp=0", extra_done); end
  endtask

  // A start in the done cycle is accepted; outputs hold until the next SIGN edge.
  task automatic test_back_to_back();
    int lat;
    int hold_bad;
    do_op(4'd6, 4'd3, lat);
    checks++; if (quotient !== 4'd2 || remainder !== 4'd0) begin failures++; $display("FAIL b2b_first got=%b/%b exp=0010/0000", quotient, remainder); end
    dividend = 4'd7; divisor = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", busy, done); end
    lat = 0;
    hold_bad = 0;
    while (!done && lat < 50) begin
      if (quotient !== 4'd2 || remainder !== 4'd0) hold_bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL b2b_hold got=%0d exp=0", hold_bad); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (quotient !== 4'd1) begin failures++; $display("FAIL b2b_q got=%b exp=0001", quotient); end
    checks++; if (remainder !== 4'd3) begin failures++; $display("FAIL b2b_r got=%b exp=0011", remainder); end
  endtask

  // Reset at the 3rd RUN edge discards the op; a fresh op then works.
  task automatic test_mid_reset();
    int lat;
    int done_cnt;
    @(negedge clk);
    dividend = 4'd7; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (quotient !== 4'd0 || remainder !== 4'd0) begin failures++; $display("FAIL mrst_results got=%b/%b exp=0000/0000", quotient, remainder); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin failures++; $display("FAIL mrst_flags busy=%b done=%b dbz=%b exp=0/0/0", busy, done, div_by_zero); end
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL mrst_no_done got=%0d exp=0", done_cnt); end
    do_op(4'd7, 4'd3, lat);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL mrst_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (quotient !== 4'd2) begin failures++; $display("FAIL mrst_q got=%b exp=0010", quotient); end
    checks++; if (remainder !== 4'd1) begin failures++; $display("FAIL mrst_r got=%b exp=0001", remainder); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_handshake();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
